// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Build option: define CMP_ARB_SIGNED_EN for two's-complement compares.
module cmp_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_eq,
  output logic                  rsp_gt,
  output logic                  rsp_lt,
  output logic                  busy
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  logic            avail;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;
  logic            found;
  int              s;

  // Slot frees in the same cycle the consumer takes the held result.
  assign avail = rst_n && (state == EMPTY || rsp_ready);

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = '0;
    found  = 1'b0;
    s      = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      idx = IDW'(s);
      if (avail && !found && req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             c_eq;
  logic             c_gt;
  logic             c_lt;

  assign a_sel = a_arr[gnt_id];
  assign b_sel = b_arr[gnt_id];
  assign c_eq  = (a_sel == b_sel);

`ifdef CMP_ARB_SIGNED_EN
  assign c_gt = ($signed(a_sel) > $signed(b_sel));
  assign c_lt = ($signed(a_sel) < $signed(b_sel));
`else
  assign c_gt = (a_sel > b_sel);
  assign c_lt = (a_sel < b_sel);
`endif

  assign req_ready = gnt;
  assign rsp_valid = (state == FULL);
  assign busy      = rsp_valid && !rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      ptr    <= '0;
      rsp_id <= '0;
      rsp_eq <= 1'b0;
      rsp_gt <= 1'b0;
      rsp_lt <= 1'b0;
    end else if (found) begin
      state  <= FULL;
      rsp_id <= gnt_id;
      rsp_eq <= c_eq;
      rsp_gt <= c_gt;
      rsp_lt <= c_lt;
      ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: behavioural model with per-cycle compare
// plus directed literal checks.
module tb_cmp_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic           rsp_eq, rsp_gt, rsp_lt, busy;

  int compared = 0;
  int mism = 0;

  cmp_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt),
    .rsp_lt(rsp_lt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference compare on plain integers: {eq, gt, lt}
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    int x, y;
`ifdef CMP_ARB_SIGNED_EN
    x = int'($signed(a));
    y = int'($signed(b));
`else
    x = int'(a);
    y = int'(b);
`endif
    return {x == y, x > y, x < y};
  endfunction

  // Model state
  logic       m_full;
  int         m_ptr;
  int         m_id;
  logic [2:0] m_res;
  int         wait_cnt [N];

  function automatic logic [N-1:0] exp_grant();
    if (!rst_n || (m_full && !rsp_ready)) return '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return N'(1) << j;
    end
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
      m_id   = 0;
      m_res  = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      logic [N-1:0] g;
      int gi;
      g  = exp_grant();
      gi = -1;
      for (int i = 0; i < N; i++) if (g[i]) gi = i;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) wait_cnt[i] = 0;
        else if (gi >= 0 && i != gi) wait_cnt[i]++;
      end
      if (gi >= 0) begin
        chk("fair_wait", 32'(wait_cnt[gi] <= N - 1), 32'd1);
        wait_cnt[gi] = 0;
        m_res  = ref_cmp(req_a[gi*W +: W], req_b[gi*W +: W]);
        m_id   = gi;
        m_full = 1'b1;
        m_ptr  = (gi + 1) % N;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", 32'(req_ready), 32'(exp_grant()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
      chk("busy", 32'(busy), 32'(m_full && !rsp_ready));
      if (m_full) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'(m_res));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [N-1:0] hs;

  initial begin
    do_reset();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request from requester 2
    rsp_ready = 1'b1;
    set_op(2, 16'h8000, 16'h7FFF);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    chk("single_valid", 32'(rsp_valid), 32'd1);
    chk("single_id", 32'(rsp_id), 32'd2);
`ifdef CMP_ARB_SIGNED_EN
    chk("single_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'b001);
`else
    chk("single_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'b010);
`endif
    step();

    // All four valid from reset: strict rotation, one per cycle
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 16'(i * 100), 16'(200));
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_order", 32'(req_ready), 32'(4'b0001 << (k % 4)));
    end
    step();
    rsp_ready = 1'b0;
    chk("bp_held_id", 32'(rsp_id), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_id", 32'(rsp_id), 32'd3);
      chk("bp_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'b010);
    end
    step();
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    step();

    // Equality and lower-than across requesters
    do_reset();
    rsp_ready = 1'b1;
    set_op(1, 16'h1234, 16'h1234);
    req_valid = 4'b0010;
    step();
    chk("eq_id", 32'(rsp_id), 32'd1);
    chk("eq_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'b100);
    set_op(3, 16'h0000, 16'hFFFF);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    chk("lt_id", 32'(rsp_id), 32'd3);
`ifdef CMP_ARB_SIGNED_EN
    chk("lt_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'b010);
`else
    chk("lt_cmp", 32'({rsp_eq, rsp_gt, rsp_lt}), 32'b001);
`endif
    step();

    // Reset while holding a result
    rsp_ready = 1'b0;
    set_op(1, 16'h0005, 16'h0003);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    chk("mid_full", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_async_drop", 32'(rsp_valid), 32'd0);
    chk("mid_ready_rst", 32'(req_ready), 32'd0);
    set_op(0, 16'h0010, 16'h0020);
    set_op(2, 16'h0030, 16'h0030);
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0100;
    chk("mid_first_id", 32'(rsp_id), 32'd0);
    step();
    req_valid = '0;
    chk("mid_second_id", 32'(rsp_id), 32'd2);
    step();

    // Fairness soak: req 0 always valid, 1..3 random, held until handshake
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !req_valid[i]) begin
          logic [W-1:0] a;
          a = 16'($urandom);
          set_op(i, a, ($urandom_range(0, 3) == 0) ? a : 16'($urandom));
          req_valid[i] = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit magnitude comparator (eq/gt/lt) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one request per cycle, evaluates the comparison, and returns a registered result tagged with the requester index. It sits between the compare clients and the shared comparator datapath, so the comparator logic is instantiated once instead of once per client.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 16: operand width in bits.
- IDW, $clog2(NREQ): width of the requester index.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_eq, rsp_gt, rsp_lt  out  1 each  comparison of A against B; exactly one of the three is high when rsp_valid=1.
- busy  out  1  high while rsp_valid=1 and rsp_ready=0.

## Operation
- FSM has two states:
  - EMPTY: no result held.
  - FULL: result held in the output register.
- Slot is available when state=EMPTY, or when state=FULL and rsp_ready=1 (pass-through in the same cycle).
- Grant selection:
  - When the slot is available, the first requester with req_valid=1 is selected, searching in round-robin order starting at ptr.
  - req_ready[i]=1 only for that requester. The grant is combinational from req_valid, ptr and state.
  - A handshake occurs when req_valid[i] and req_ready[i] are both 1.
- On a handshake at edge N:
  - Operands of i are compared.
  - rsp_eq/gt/lt and rsp_id=i are registered.
  - rsp_valid=1 from edge N onward.
  - ptr becomes (i+1) mod NREQ.
  - State goes to FULL.
- On rsp_valid & rsp_ready with no new handshake in the same cycle: state goes to EMPTY and rsp_valid=0.
- Simultaneous consume and accept: the result register is overwritten with the new result, rsp_valid stays 1, and there is no bubble.
- ptr changes only on a handshake. With no requests, ptr and the output registers hold their values.
- Requester rules:
  - Once a requester raises req_valid, it holds req_valid and its operands stable until its handshake.
  - A request lowered without a handshake is simply never granted. No error is flagged.
- Fairness: a continuously asserted request is granted within NREQ handshakes.
- Output stability: while state=FULL and rsp_ready=0, rsp_* are held stable and all req_ready bits are 0.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_eq=0, rsp_gt=0, rsp_lt=0, busy=0.
  - ptr=0, state=EMPTY.
  - req_ready=0 while rst_n=0.
- Latency: a request handshaken at edge N presents its result from edge N through at least the cycle after N.
- Throughput: one compare per cycle while rsp_ready=1.
- Reset asserted mid-operation: any held result is discarded immediately (asynchronously). After rst_n deasserts, the first grant starts from requester 0.
- req_ready has a combinational path from req_valid and rsp_ready; there is no combinational path from req_a/req_b to any output.

## Configuration
- CMP_ARB_SIGNED_EN:
  - Defined: operands are compared as two's-complement signed values.
  - Undefined: operands are compared as unsigned.
- rsp_eq is identical in both builds.

## Test plan
- Single request: WIDTH=16, requester 2 sends A=0x8000, B=0x7FFF, rsp_ready=1. Expected response one cycle later: rsp_id=2.
  - Unsigned build: gt=1.
  - CMP_ARB_SIGNED_EN build: lt=1.
- All four requesters valid continuously with rsp_ready=1 from reset: grants in order 0,1,2,3,0,…, one per cycle, no gaps.
- Backpressure: rsp_ready=0 for 5 cycles after a result.
  - rsp_* stay stable, busy=1, req_ready=0.
  - When rsp_ready rises, the next grant happens in that same cycle.
- Equality across requesters:
  - Requester 1 sends A=B=0x1234: expect eq=1, gt=0, lt=0.
  - Requester 3 sends A=0x0000, B=0xFFFF: expect lt=1 in the unsigned build.
- Reset mid-flight: assert rst_n=0 while state=FULL.
  - rsp_valid drops without a clock edge.
  - After release, with requesters 2 and 0 both pending, requester 0 is granted first.
- Fairness: requester 0 valid continuously, requesters 1–3 toggling randomly, 1000 cycles. Any request that stays valid is granted within 4 handshakes. Every result matches a reference compare.
